// File: rtl/rom_step_controller.sv
// Push-button front end for rom_reader: it debounces the buttons and shapes each press into one step pulse,
// with an auto-scan sweep. Optional hold-to-repeat is enabled by defining ROM_STEP_HOLD_REPEAT_EN.
module rom_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1000,
  parameter int unsigned PULSE_CYCLES        = 4,
  parameter int unsigned GAP_CYCLES          = 4,
  parameter int unsigned AUTO_PERIOD_CYCLES  = 100,
  parameter int unsigned ADDRESS_WIDTH       = 9,
  parameter int unsigned REPEAT_DELAY_CYCLES = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_inc,
  input  logic btn_dec,
  input  logic btn_auto,
  output logic increment_address,
  output logic decrement_address,
  output logic auto_active,
  output logic busy
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1)    ? $clog2(DEBOUNCE_CYCLES)    : 1;
  localparam int unsigned PW     = (PULSE_CYCLES > 1)       ? $clog2(PULSE_CYCLES)       : 1;
  localparam int unsigned GW     = (GAP_CYCLES > 1)         ? $clog2(GAP_CYCLES)         : 1;
  localparam int unsigned AW     = (AUTO_PERIOD_CYCLES > 1) ? $clog2(AUTO_PERIOD_CYCLES) : 1;
  localparam int unsigned STEP_W = ADDRESS_WIDTH + 1;
  localparam logic [STEP_W-1:0] STEP_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2) && (PULSE_CYCLES >= 1) &&
                             (GAP_CYCLES >= 2) && (AUTO_PERIOD_CYCLES >= 1) &&
                             (REPEAT_DELAY_CYCLES >= 1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE_INC,
    PULSE_DEC,
    GAP,
    AUTO_WAIT
  } state_t;

  // Bit order for the per-button vectors: [0]=inc, [1]=dec, [2]=auto.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q;
  logic [2:0]      sync2_q;
  logic [2:0]      level_q;
  logic [2:0]      level_d_q;
  logic [2:0]      req_q;
  logic [DB_W-1:0] db_cnt_q [3];

  assign btn_raw = {btn_auto, btn_dec, btn_inc};

  // Synchronize, debounce and edge-detect the three buttons.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      level_d_q <= '0;
      req_q     <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_d_q <= level_q;
      req_q     <= level_q & ~level_d_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  state_t            state_q, state_d;
  logic              auto_q, auto_d;
  logic              stop_q, stop_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [PW-1:0]     pulse_q, pulse_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [AW-1:0]     wait_q, wait_d;
  logic              req_auto;
  logic              req_inc_any;
  logic              req_dec_any;

  assign req_auto = req_q[2];

`ifdef ROM_STEP_HOLD_REPEAT_EN
  localparam int unsigned HW = (REPEAT_DELAY_CYCLES > 1) ? $clog2(REPEAT_DELAY_CYCLES) : 1;

  logic          hold_run_q;
  logic          hold_dir_q;
  logic          hold_done_q;
  logic          rpt_pend_q;
  logic [HW-1:0] hold_cnt_q;
  logic [AW-1:0] rpt_cnt_q;
  logic          held;

  assign held        = hold_dir_q ? level_q[1] : level_q[0];
  assign req_inc_any = req_q[0] | (rpt_pend_q & ~hold_dir_q);
  assign req_dec_any = req_q[1] | (rpt_pend_q & hold_dir_q);

  // Hold timer: after the delay, post a repeat request every auto period until release.
  always_ff @(posedge clk) begin
    if (!reset_n || auto_q || (hold_run_q && !held)) begin
      hold_run_q  <= 1'b0;
      hold_dir_q  <= 1'b0;
      hold_done_q <= 1'b0;
      rpt_pend_q  <= 1'b0;
      hold_cnt_q  <= '0;
      rpt_cnt_q   <= '0;
    end else if (state_q == IDLE && !req_auto && (req_q[0] ^ req_q[1])) begin
      hold_run_q  <= 1'b1;
      hold_dir_q  <= req_q[1];
      hold_done_q <= 1'b0;
      rpt_pend_q  <= 1'b0;
      hold_cnt_q  <= '0;
      rpt_cnt_q   <= '0;
    end else if (hold_run_q) begin
      if (rpt_pend_q && state_q == IDLE && !req_auto) rpt_pend_q <= 1'b0;
      if (!hold_done_q) begin
        if (hold_cnt_q == HW'(REPEAT_DELAY_CYCLES - 1)) hold_done_q <= 1'b1;
        else hold_cnt_q <= hold_cnt_q + HW'(1);
      end else if (rpt_cnt_q == AW'(AUTO_PERIOD_CYCLES - 1)) begin
        rpt_cnt_q  <= '0;
        rpt_pend_q <= 1'b1;
      end else begin
        rpt_cnt_q <= rpt_cnt_q + AW'(1);
      end
    end
  end
`else
  assign req_inc_any = req_q[0];
  assign req_dec_any = req_q[1];
`endif

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      auto_q  <= 1'b0;
      stop_q  <= 1'b0;
      step_q  <= '0;
      pulse_q <= '0;
      gap_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    stop_d  = stop_q;
    step_d  = step_q;
    pulse_d = pulse_q;
    gap_d   = gap_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        stop_d  = 1'b0;
        pulse_d = '0;
        gap_d   = '0;
        wait_d  = '0;
        if (req_auto) begin
          auto_d  = 1'b1;
          step_d  = '0;
          state_d = AUTO_WAIT;
        end else if (req_inc_any && !req_dec_any) begin
          state_d = PULSE_INC;
        end else if (req_dec_any && !req_inc_any) begin
          state_d = PULSE_DEC;
        end
      end
      PULSE_INC, PULSE_DEC: begin
        if (req_auto && auto_q) stop_d = 1'b1;
        if (pulse_q == PW'(PULSE_CYCLES - 1)) begin
          pulse_d = '0;
          state_d = GAP;
        end else begin
          pulse_d = pulse_q + PW'(1);
        end
      end
      GAP: begin
        if (req_auto && auto_q) stop_d = 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d = '0;
          if (auto_q && !stop_q && !req_auto && step_q != STEP_FULL) begin
            state_d = AUTO_WAIT;
          end else begin
            auto_d  = 1'b0;
            stop_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      AUTO_WAIT: begin
        if (req_auto) begin
          auto_d  = 1'b0;
          wait_d  = '0;
          state_d = IDLE;
        end else if (wait_q == AW'(AUTO_PERIOD_CYCLES - 1)) begin
          wait_d  = '0;
          step_d  = step_q + STEP_W'(1);
          state_d = PULSE_INC;
        end else begin
          wait_d = wait_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, one cycle behind the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      increment_address <= 1'b0;
      decrement_address <= 1'b0;
      busy              <= 1'b0;
    end else begin
      increment_address <= (state_q == PULSE_INC);
      decrement_address <= (state_q == PULSE_DEC);
      busy              <= (state_q != IDLE);
    end
  end

  assign auto_active = auto_q;

  a_params_ok: assert property (@(posedge clk) PARAMS_OK);
  a_exclusive: assert property (@(posedge clk) !(increment_address && decrement_address));

endmodule

// File: tb/tb_rom_step_controller.sv
// Directed bench for rom_step_controller: press vectors from a table and hand-written multi-cycle sequences.
module tb_rom_step_controller;

  localparam int D   = 8;
  localparam int PC  = 4;
  localparam int GC  = 4;
  localparam int AP  = 16;
  localparam int AWD = 3;
  localparam int LAT = D + 4;

  logic clk;
  logic reset_n;
  logic btn_inc;
  logic btn_dec;
  logic btn_auto;
  logic increment_address;
  logic decrement_address;
  logic auto_active;
  logic busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rom_step_controller #(
    .DEBOUNCE_CYCLES    (D),
    .PULSE_CYCLES       (PC),
    .GAP_CYCLES         (GC),
    .AUTO_PERIOD_CYCLES (AP),
    .ADDRESS_WIDTH      (AWD),
    .REPEAT_DELAY_CYCLES(64)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .btn_inc          (btn_inc),
    .btn_dec          (btn_dec),
    .btn_auto         (btn_auto),
    .increment_address(increment_address),
    .decrement_address(decrement_address),
    .auto_active      (auto_active),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic inc;
    logic dec;
    int   hold;
    int   exp_inc;
    int   exp_dec;
  } vec_t;

  vec_t vecs [6];

  int e0, n_inc, n_dec, hi, busy_n, both, rise, ar, af, lf, falls, press_e, rel_n;
  logic p_inc, p_dec, seen;
  int rises [10];

  initial begin
    vecs[0] = '{inc: 1'b1, dec: 1'b0, hold: 40, exp_inc: 1, exp_dec: 0};
    vecs[1] = '{inc: 1'b0, dec: 1'b1, hold: 40, exp_inc: 0, exp_dec: 1};
    vecs[2] = '{inc: 1'b1, dec: 1'b1, hold: 40, exp_inc: 0, exp_dec: 0};
    vecs[3] = '{inc: 1'b1, dec: 1'b0, hold: 5,  exp_inc: 0, exp_dec: 0};
    vecs[4] = '{inc: 1'b1, dec: 1'b0, hold: 7,  exp_inc: 0, exp_dec: 0};
    vecs[5] = '{inc: 1'b0, dec: 1'b1, hold: 8,  exp_inc: 0, exp_dec: 1};

    reset_n = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_auto = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_inc", int'(increment_address), 0);
    check("reset_dec", int'(decrement_address), 0);
    check("reset_auto", int'(auto_active), 0);
    check("reset_busy", int'(busy), 0);

    // Table of single presses.
    for (int v = 0; v < 6; v++) begin
      btn_inc = vecs[v].inc; btn_dec = vecs[v].dec; e0 = cyc + 1;
      n_inc = 0; n_dec = 0; hi = 0; busy_n = 0; both = 0; rise = -1; p_inc = 0; p_dec = 0;
      for (int n = 0; n < vecs[v].hold + 40; n++) begin
        @(negedge clk);
        if (increment_address && !p_inc) begin n_inc++; if (rise < 0) rise = cyc - e0; end
        if (decrement_address && !p_dec) begin n_dec++; if (rise < 0) rise = cyc - e0; end
        hi     += int'(increment_address) + int'(decrement_address);
        busy_n += int'(busy);
        both   += int'(increment_address & decrement_address);
        p_inc = increment_address; p_dec = decrement_address;
        if (n == vecs[v].hold - 1) begin btn_inc = 1'b0; btn_dec = 1'b0; end
      end
      check($sformatf("v%0d_inc_pulses", v), n_inc, vecs[v].exp_inc);
      check($sformatf("v%0d_dec_pulses", v), n_dec, vecs[v].exp_dec);
      check($sformatf("v%0d_high_cycles", v), hi, PC * (vecs[v].exp_inc + vecs[v].exp_dec));
      check($sformatf("v%0d_busy_cycles", v), busy_n, (PC + GC) * (vecs[v].exp_inc + vecs[v].exp_dec));
      check($sformatf("v%0d_overlap", v), both, 0);
      if (vecs[v].exp_inc + vecs[v].exp_dec == 1) check($sformatf("v%0d_latency", v), rise, LAT);
    end

    // Bouncing decrement button, settling high after 30 cycles.
    btn_dec = 1'b1; e0 = cyc + 1; n_inc = 0; n_dec = 0; rise = -1; p_inc = 0; p_dec = 0; hi = 0;
    for (int n = 0; n < 90; n++) begin
      @(negedge clk);
      if (increment_address && !p_inc) n_inc++;
      if (decrement_address && !p_dec) begin n_dec++; if (rise < 0) rise = cyc - e0; end
      hi += int'(decrement_address);
      p_inc = increment_address; p_dec = decrement_address;
      if (n + 1 < 30) btn_dec = (((n + 1) / 3) % 2 == 0);
      else btn_dec = (n < 89);
    end
    check("bounce_dec_pulses", n_dec, 1);
    check("bounce_inc_pulses", n_inc, 0);
    check("bounce_latency", rise, 30 + LAT);
    check("bounce_width", hi, PC);
    repeat (30) @(negedge clk);

    // Full auto sweep with manual presses ignored.
    btn_auto = 1'b1; e0 = cyc + 1; n_inc = 0; n_dec = 0; hi = 0; ar = -1; af = -1; lf = -1;
    p_inc = 0; p_dec = 0; seen = 0;
    for (int n = 0; n < 320; n++) begin
      @(negedge clk);
      if (auto_active && !seen) begin ar = cyc; seen = 1; end
      if (!auto_active && seen && af < 0) af = cyc;
      if (increment_address && !p_inc) begin if (n_inc < 10) rises[n_inc] = cyc; n_inc++; end
      if (!increment_address && p_inc) lf = cyc;
      if (decrement_address && !p_dec) n_dec++;
      hi += int'(increment_address);
      p_inc = increment_address; p_dec = decrement_address;
      if (n == 11) btn_auto = 1'b0;
      btn_inc = (n >= 60 && n < 80);
      btn_dec = (n >= 100 && n < 120);
    end
    check("auto_start", ar - e0, D + 3);
    check("auto_pulses", n_inc, 8);
    check("auto_dec_pulses", n_dec, 0);
    check("auto_high_cycles", hi, 8 * PC);
    if (n_inc >= 1) check("auto_first_step", rises[0] - ar, AP + 1);
    for (int j = 1; j < 8; j++)
      if (j < n_inc) check($sformatf("auto_period_%0d", j), rises[j] - rises[j-1], AP + PC + GC);
    check("auto_end", af - lf, GC - 1);
    check("auto_end_busy", int'(busy), 0);

    // Stop request during the third wait.
    btn_auto = 1'b1; n_inc = 0; falls = 0; af = -1; seen = 0; p_inc = 0; press_e = -1; rel_n = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (auto_active) seen = 1;
      if (!auto_active && seen && af < 0) af = cyc;
      if (increment_address && !p_inc) n_inc++;
      if (n == 11) btn_auto = 1'b0;
      if (n == rel_n) btn_auto = 1'b0;
      if (!increment_address && p_inc) begin
        falls++;
        if (falls == 2) begin btn_auto = 1'b1; press_e = cyc + 1; rel_n = n + 12; end
      end
      p_inc = increment_address;
    end
    check("stop_pulses", n_inc, 2);
    check("stop_latency", af - press_e, D + 3);
    check("stop_busy", int'(busy), 0);

    // Reset in the second cycle of an increment pulse.
    btn_inc = 1'b1; seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (increment_address) seen = 1;
    end
    check("rst_pulse_seen", int'(seen), 1);
    @(negedge clk);
    reset_n = 1'b0; btn_inc = 1'b0;
    @(negedge clk);
    check("rst_inc", int'(increment_address), 0);
    check("rst_dec", int'(decrement_address), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_auto", int'(auto_active), 0);
    reset_n = 1'b1;
    busy_n = 0; n_inc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      busy_n += int'(busy);
      n_inc  += int'(increment_address) + int'(decrement_address);
    end
    check("post_rst_busy", busy_n, 0);
    check("post_rst_pulses", n_inc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
